cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter.sv | 72 +++++++
 tb/tb_cdb_arbiter.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdb_arbiter_if.sv
// Requester-to-CDB bus bundle: per-unit result offers in, one-hot grant and
// the registered common-data-bus broadcast out.
interface cdb_arbiter_if #(
    parameter int N_REQ  = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
);
    // Handshake: requester i raises req_valid[i] with req_tag/req_data slice i
    // and holds all three stable until the cycle req_ready[i] is also high;
    // that cycle is the transfer. cdb_* shows the transferred result one cycle later.
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*TAG_W-1:0]  req_tag;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    cdb_valid;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_data;

    modport master (
        output req_valid, req_tag, req_data,
        input  req_ready, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  req_valid, req_tag, req_data,
        output req_ready, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one ready functional unit
// per cycle and broadcasts its tag/result on the registered CDB.
module cdb_arbiter #(
    parameter int N_REQ  = 5,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    cdb_arbiter_if.slave     bus,
    output logic [PTR_W-1:0] dbg_rr_ptr
);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  sel;
    logic              hit;
    logic              grant_ok;
    logic [N_REQ-1:0]  grant;
    logic [PTR_W-1:0]  next_ptr;
    logic              cdb_valid_q;
    logic [TAG_W-1:0]  cdb_tag_q;
    logic [DATA_W-1:0] cdb_data_q;

    // Modulo-N_REQ add; N_REQ need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!hit && bus.req_valid[ptr_add(rr_ptr, k)]) begin
                hit = 1'b1;
                sel = ptr_add(rr_ptr, k);
            end
        end
    end

    // Flush and reset both veto the grant, so a grant always means a transfer.
    assign grant_ok = hit & ~flush & ~rst;
    assign grant    = grant_ok ? (N_REQ'(1) << sel) : '0;
    assign next_ptr = (sel == PTR_W'(N_REQ - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr      <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= grant_ok;
            if (grant_ok) begin
                cdb_tag_q  <= bus.req_tag[sel*TAG_W +: TAG_W];
                cdb_data_q <= bus.req_data[sel*DATA_W +: DATA_W];
                rr_ptr     <= next_ptr;
            end
        end
    end

    assign bus.req_ready = grant;
    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_data  = cdb_data_q;
    assign dbg_rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: a rotating-priority model plus broadcast
// scoreboard checked every cycle, and literal expectations for each scenario.
module tb_cdb_arbiter;
    localparam int N  = 5;
    localparam int DW = 32;
    localparam int TW = 4;
    localparam int PW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic [PW-1:0] dbg_rr_ptr;

    cdb_arbiter_if #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) bus ();

    cdb_arbiter #(.N_REQ(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .bus        (bus),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int            m_ptr   = 0;
    logic          m_valid = 1'b0;
    logic [TW-1:0] m_tag   = '0;
    logic [DW-1:0] m_data  = '0;
    logic [TW+DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    endtask

    // Requester the rules pick right now, or -1 when nobody may be granted.
    function automatic int model_grant();
        if (rst !== 1'b0 || flush !== 1'b0) return -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (bus.req_valid[i] === 1'b1) return i;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_ptr   = 0;
            m_valid = 1'b0;
            m_tag   = '0;
            m_data  = '0;
            exp_q.delete();
        end else begin
            g = model_grant();
            if (g >= 0) begin
                m_valid = 1'b1;
                m_tag   = bus.req_tag[g*TW +: TW];
                m_data  = bus.req_data[g*DW +: DW];
                m_ptr   = (g + 1) % N;
                exp_q.push_back({m_tag, m_data});
            end else begin
                m_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        int g;
        logic [N-1:0] oh;
        logic [TW+DW-1:0] e;
        g  = model_grant();
        oh = (g < 0) ? '0 : (N'(1) << g);
        chk("req_ready", bus.req_ready, oh);
        chk("cdb_valid", bus.cdb_valid, m_valid);
        chk("cdb_tag", bus.cdb_tag, m_tag);
        chk("cdb_data", bus.cdb_data, m_data);
        chk("rr_ptr", dbg_rr_ptr, m_ptr);
        if (bus.cdb_valid === 1'b1) begin
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_entry", {bus.cdb_tag, bus.cdb_data}, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_slot(input int i, input logic [TW-1:0] tag, input logic [DW-1:0] data);
        bus.req_tag[i*TW +: TW]  = tag;
        bus.req_data[i*DW +: DW] = data;
    endtask

    initial begin
        int exp_g[6];
        logic [N-1:0] one;
        exp_g = '{0, 1, 2, 3, 4, 0};
        one   = 1;

        rst = 1'b1;
        flush = 1'b0;
        bus.req_valid = '0;
        bus.req_tag   = '0;
        bus.req_data  = '0;
        tick();
        chk("rst_valid", bus.cdb_valid, 0);
        chk("rst_tag", bus.cdb_tag, 0);
        chk("rst_data", bus.cdb_data, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_ptr", dbg_rr_ptr, 0);
        tick();
        rst = 1'b0;

        // single request
        set_slot(2, 4'd3, 32'h0000_00AA);
        bus.req_valid = 5'b00100;
        #1 chk("single_ready", bus.req_ready, 5'b00100);
        tick();
        bus.req_valid = '0;
        chk("single_valid", bus.cdb_valid, 1);
        chk("single_tag", bus.cdb_tag, 3);
        chk("single_data", bus.cdb_data, 32'hAA);
        chk("single_ptr", dbg_rr_ptr, 3);

        // idle: broadcast invalid, payload and pointer hold
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("idle_valid", bus.cdb_valid, 0);
            chk("idle_tag", bus.cdb_tag, 3);
            chk("idle_data", bus.cdb_data, 32'hAA);
            chk("idle_ptr", dbg_rr_ptr, 3);
        end

        // wrap from pointer 4, unselected slots carry X
        set_slot(3, 4'd5, 32'h33);
        bus.req_valid = 5'b01000;
        tick();
        chk("wrap_ptr4", dbg_rr_ptr, 4);
        set_slot(4, 4'd9, 32'h44);
        set_slot(0, 4'd1, 32'h11);
        bus.req_tag[1*TW +: TW]  = 'x;
        bus.req_data[1*DW +: DW] = 'x;
        bus.req_tag[2*TW +: TW]  = 'x;
        bus.req_data[2*DW +: DW] = 'x;
        bus.req_valid = 5'b10001;
        #1 chk("wrap_ready4", bus.req_ready, 5'b10000);
        tick();
        bus.req_valid = 5'b00001;
        chk("wrap_tag4", bus.cdb_tag, 9);
        chk("wrap_data4", bus.cdb_data, 32'h44);
        #1 chk("wrap_ready0", bus.req_ready, 5'b00001);
        tick();
        bus.req_valid = '0;
        chk("wrap_tag0", bus.cdb_tag, 1);
        chk("wrap_data0", bus.cdb_data, 32'h11);
        chk("wrap_ptr1", dbg_rr_ptr, 1);

        // flush holds off a waiting requester for two cycles
        set_slot(1, 4'd6, 32'h66);
        set_slot(2, 4'd0, 32'h0);
        bus.req_valid = 5'b00010;
        flush = 1'b1;
        #1 chk("flush_ready", bus.req_ready, 0);
        tick();
        chk("flush_valid", bus.cdb_valid, 0);
        chk("flush_ptr", dbg_rr_ptr, 1);
        tick();
        chk("flush_valid2", bus.cdb_valid, 0);
        chk("flush_ptr2", dbg_rr_ptr, 1);
        flush = 1'b0;
        #1 chk("post_flush_ready", bus.req_ready, 5'b00010);
        tick();
        bus.req_valid = '0;
        chk("post_flush_tag", bus.cdb_tag, 6);
        chk("post_flush_data", bus.cdb_data, 32'h66);
        chk("post_flush_ptr", dbg_rr_ptr, 2);

        // all-request fairness from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) set_slot(i, TW'(i + 1), 32'h100 + i);
        bus.req_valid = 5'b11111;
        for (int k = 0; k < 6; k++) begin
            #1 chk("fair_grant", bus.req_ready, one << exp_g[k]);
            tick();
            chk("fair_valid", bus.cdb_valid, 1);
            chk("fair_tag", bus.cdb_tag, exp_g[k] + 1);
        end
        bus.req_valid = '0;

        // asynchronous reset between edges while the bus is busy
        set_slot(1, 4'd7, 32'h77);
        bus.req_valid = 5'b00010;
        tick();
        bus.req_valid = '0;
        chk("pre_arst_valid", bus.cdb_valid, 1);
        chk("pre_arst_tag", bus.cdb_tag, 7);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", bus.cdb_valid, 0);
        chk("arst_tag", bus.cdb_tag, 0);
        chk("arst_data", bus.cdb_data, 0);
        chk("arst_ptr", dbg_rr_ptr, 0);
        set_slot(3, 4'd8, 32'h88);
        set_slot(4, 4'd10, 32'hA0);
        bus.req_valid = 5'b11000;
        #1 chk("arst_ready", bus.req_ready, 0);
        tick();
        rst = 1'b0;
        #1 chk("post_arst_ready", bus.req_ready, 5'b01000);
        tick();
        chk("post_arst_tag", bus.cdb_tag, 8);
        chk("post_arst_data", bus.cdb_data, 32'h88);
        #1 chk("post_arst_ready4", bus.req_ready, 5'b10000);
        tick();
        bus.req_valid = '0;
        chk("post_arst_tag4", bus.cdb_tag, 10);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
